rcv_block_fifo: RTL and testbench

RCV_BLOCK_FIFO -- requirements
Module: rcv_block_fifo

---
 rtl/rcv_block_fifo_if.sv | 27 ++
 rtl/rcv_block_fifo.sv | 77 +++++++
 tb/tb_rcv_block_fifo.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/rcv_block_fifo_if.sv
// Bus bundle between the AHB receive path, crypto core and the 8-word receive FIFO.
// slave modport is the FIFO side; master modport is the producer/consumer side.
interface rcv_block_fifo_if;
  logic        rcv_enq_word;
  logic [31:0] HWDATA;
  logic        flush;
  logic        block_deq;
  logic [63:0] block_out;
  logic        block_valid;
  logic        rcv_fifo_full;
  logic        rcv_fifo_empty;
  logic [3:0]  word_count;
  logic        overflow;
  logic        underflow;

  modport slave (
    input  rcv_enq_word, HWDATA, flush, block_deq,
    output block_out, block_valid, rcv_fifo_full, rcv_fifo_empty,
    output word_count, overflow, underflow
  );

  modport master (
    output rcv_enq_word, HWDATA, flush, block_deq,
    input  block_out, block_valid, rcv_fifo_full, rcv_fifo_empty,
    input  word_count, overflow, underflow
  );
endinterface

// File: rtl/rcv_block_fifo.sv
// 8 x 32-bit word FIFO packing pairs into 64-bit blocks; status outputs have zero latency
// from registered state. Full drops enqueues (overflow pulse); dequeue below 2 words is ignored (underflow pulse).
module rcv_block_fifo (
  input  logic              HCLK,
  input  logic              HRESETn,
  rcv_block_fifo_if.slave   bus
);

  logic [2:0]  wr_ptr_q, wr_ptr_d;
  logic [2:0]  rd_ptr_q, rd_ptr_d;
  logic [3:0]  count_q, count_d;
  logic        overflow_q, overflow_d;
  logic        underflow_q, underflow_d;
  logic [31:0] mem_q [8];
  logic [31:0] mem_d [8];
  logic        enq_ok, deq_ok;
  logic [2:0]  rd_pair;

  always_comb begin
    enq_ok      = bus.rcv_enq_word && (count_q < 4'd8);
    deq_ok      = bus.block_deq && (count_q >= 4'd2);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    mem_d       = mem_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    // Flush wins outright: same-cycle strobes vanish without raising any error pulse.
    if (bus.flush) begin
      wr_ptr_d = 3'd0;
      rd_ptr_d = 3'd0;
      count_d  = 4'd0;
    end else begin
      if (enq_ok) begin
        mem_d[wr_ptr_q] = bus.HWDATA;
        wr_ptr_d        = wr_ptr_q + 3'd1;
      end
      if (deq_ok) begin
        rd_ptr_d = rd_ptr_q + 3'd2;
      end
      count_d     = count_q + {3'b000, enq_ok} - (deq_ok ? 4'd2 : 4'd0);
      overflow_d  = bus.rcv_enq_word && !enq_ok;
      underflow_d = bus.block_deq && !deq_ok;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr_q    <= 3'd0;
      rd_ptr_q    <= 3'd0;
      count_q     <= 4'd0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Word storage is deliberately left out of reset; stale words are hidden by count.
  always_ff @(posedge HCLK) begin
    mem_q <= mem_d;
  end

  assign rd_pair            = rd_ptr_q + 3'd1;
  assign bus.block_out      = {mem_q[rd_ptr_q], mem_q[rd_pair]};
  assign bus.block_valid    = (count_q >= 4'd2);
  assign bus.rcv_fifo_full  = (count_q == 4'd8);
  assign bus.rcv_fifo_empty = (count_q == 4'd0);
  assign bus.word_count     = count_q;
  assign bus.overflow       = overflow_q;
  assign bus.underflow      = underflow_q;

endmodule

// File: tb/tb_rcv_block_fifo.sv
// Bench for rcv_block_fifo: directed vector table, reset/flush sequences, then random traffic vs a queue model.
module tb_rcv_block_fifo;

  logic HCLK;
  logic HRESETn;
  rcv_block_fifo_if bus();

  rcv_block_fifo dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int tests = 0;
  int fails = 0;

  // Reference: FIFO of words, head at index 0; error pulses expected after the last edge.
  logic [31:0] q[$];
  logic        exp_ovf;
  logic        exp_udf;

  typedef struct {
    logic        enq;
    logic [31:0] dat;
    logic        deq;
    logic        fl;
    logic [3:0]  cnt;
    logic        vld;
    logic [63:0] blk;
    logic        ovf;
    logic        udf;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_step(input logic enq, input logic [31:0] d, input logic deq, input logic fl);
    int n;
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
    if (fl) begin
      q.delete();
    end else begin
      n = q.size();
      if (deq) begin
        if (n >= 2) begin
          void'(q.pop_front());
          void'(q.pop_front());
        end else begin
          exp_udf = 1'b1;
        end
      end
      if (enq) begin
        if (n < 8) q.push_back(d);
        else exp_ovf = 1'b1;
      end
    end
  endtask

  // Called at 1 time unit after a rising edge; applies inputs for the next edge.
  task automatic drive(input logic enq, input logic [31:0] d, input logic deq, input logic fl);
    bus.rcv_enq_word = enq;
    bus.HWDATA       = d;
    bus.block_deq    = deq;
    bus.flush        = fl;
    @(posedge HCLK);
    #1;
    model_step(enq, d, deq, fl);
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".count"}, 64'(bus.word_count), 64'(q.size()));
    chk({tag, ".empty"}, 64'(bus.rcv_fifo_empty), 64'(q.size() == 0));
    chk({tag, ".full"}, 64'(bus.rcv_fifo_full), 64'(q.size() == 8));
    chk({tag, ".valid"}, 64'(bus.block_valid), 64'(q.size() >= 2));
    chk({tag, ".ovf"}, 64'(bus.overflow), 64'(exp_ovf));
    chk({tag, ".udf"}, 64'(bus.underflow), 64'(exp_udf));
    if (q.size() >= 2) chk({tag, ".block"}, bus.block_out, {q[0], q[1]});
  endtask

  initial begin
    vecs[0]  = '{1'b1, 32'h11111111, 1'b0, 1'b0, 4'd1, 1'b0, 64'h0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 32'h0,        1'b1, 1'b0, 4'd1, 1'b0, 64'h0, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 32'h0,        1'b0, 1'b0, 4'd1, 1'b0, 64'h0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 32'h22222222, 1'b0, 1'b0, 4'd2, 1'b1, 64'h11111111_22222222, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 32'h33333333, 1'b0, 1'b0, 4'd3, 1'b1, 64'h11111111_22222222, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 32'h44444444, 1'b1, 1'b0, 4'd2, 1'b1, 64'h33333333_44444444, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 32'h55555555, 1'b0, 1'b0, 4'd3, 1'b1, 64'h33333333_44444444, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 32'h66666666, 1'b0, 1'b0, 4'd4, 1'b1, 64'h33333333_44444444, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 32'h77777777, 1'b0, 1'b0, 4'd5, 1'b1, 64'h33333333_44444444, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 32'h88888888, 1'b0, 1'b0, 4'd6, 1'b1, 64'h33333333_44444444, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 32'h99999999, 1'b0, 1'b0, 4'd7, 1'b1, 64'h33333333_44444444, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 32'hAAAAAAAA, 1'b0, 1'b0, 4'd8, 1'b1, 64'h33333333_44444444, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 4'd8, 1'b1, 64'h33333333_44444444, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 4'd6, 1'b1, 64'h55555555_66666666, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 32'h0,        1'b0, 1'b0, 4'd6, 1'b1, 64'h55555555_66666666, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 32'h0,        1'b1, 1'b0, 4'd4, 1'b1, 64'h77777777_88888888, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 32'h0,        1'b1, 1'b0, 4'd2, 1'b1, 64'h99999999_AAAAAAAA, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 4'd0, 1'b0, 64'h0, 1'b0, 1'b0};

    // Reset with strobes active: nothing may leak through after release.
    HRESETn          = 1'b0;
    bus.rcv_enq_word = 1'b1;
    bus.HWDATA       = 32'h0BAD0BAD;
    bus.block_deq    = 1'b1;
    bus.flush        = 1'b0;
    q.delete();
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    chk("rst.count", 64'(bus.word_count), 64'd0);
    chk("rst.empty", 64'(bus.rcv_fifo_empty), 64'd1);
    chk("rst.full", 64'(bus.rcv_fifo_full), 64'd0);
    chk("rst.valid", 64'(bus.block_valid), 64'd0);
    chk("rst.ovf", 64'(bus.overflow), 64'd0);
    chk("rst.udf", 64'(bus.underflow), 64'd0);
    bus.rcv_enq_word = 1'b0;
    bus.block_deq    = 1'b0;
    HRESETn          = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check_model("post_rst");

    foreach (vecs[i]) begin
      drive(vecs[i].enq, vecs[i].dat, vecs[i].deq, vecs[i].fl);
      chk($sformatf("vec%0d.count", i), 64'(bus.word_count), 64'(vecs[i].cnt));
      chk($sformatf("vec%0d.valid", i), 64'(bus.block_valid), 64'(vecs[i].vld));
      chk($sformatf("vec%0d.full", i), 64'(bus.rcv_fifo_full), 64'(vecs[i].cnt == 4'd8));
      chk($sformatf("vec%0d.empty", i), 64'(bus.rcv_fifo_empty), 64'(vecs[i].cnt == 4'd0));
      chk($sformatf("vec%0d.ovf", i), 64'(bus.overflow), 64'(vecs[i].ovf));
      chk($sformatf("vec%0d.udf", i), 64'(bus.underflow), 64'(vecs[i].udf));
      if (vecs[i].vld) chk($sformatf("vec%0d.block", i), bus.block_out, vecs[i].blk);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check_model("after_table");

    // Flush with 5 words stored and a concurrent enqueue.
    for (int i = 0; i < 5; i++) drive(1'b1, 32'hF0000000 + 32'(i), 1'b0, 1'b0);
    check_model("fill5");
    drive(1'b1, 32'h12345678, 1'b0, 1'b1);
    check_model("flush5");
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check_model("flush5_idle");

    // Asynchronous reset mid-fill, then the first words land at slot 0 onward.
    for (int i = 0; i < 3; i++) drive(1'b1, 32'hE0000000 + 32'(i), 1'b0, 1'b0);
    bus.rcv_enq_word = 1'b1;
    bus.HWDATA       = 32'h0BADF00D;
    #3;
    HRESETn = 1'b0;
    #1;
    q.delete();
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
    check_model("async_rst");
    @(posedge HCLK);
    #1;
    bus.rcv_enq_word = 1'b0;
    HRESETn          = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check_model("rst_release");
    drive(1'b1, 32'hCAFE0001, 1'b0, 1'b0);
    drive(1'b1, 32'hCAFE0002, 1'b0, 1'b0);
    check_model("refill");

    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 99) < 60), $urandom, ($urandom_range(0, 99) < 35),
            ($urandom_range(0, 99) < 2));
      check_model($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
